// File: rtl/fir_serial_mac.sv
// Time-multiplexed Q1.15 FIR: one sample in, TAPS serial saturating
// MAC cycles through a single 16x16 multiplier, one sample out.
module fir_serial_mac #(
  parameter int TAPS = 4,
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_data,
  output logic          out_valid,
  output logic [15:0]   out_data,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic signed [15:0] x_q [TAPS];
  logic signed [15:0] x_d [TAPS];
  logic signed [15:0] c_q [TAPS];
  logic signed [15:0] c_d [TAPS];
  logic signed [15:0] acc_q, acc_d;
  logic signed [15:0] out_data_q, out_data_d;
  logic [AW-1:0]      idx_q, idx_d;

  logic               accept;
  logic               coef_ok;
  logic signed [31:0] prod;
  logic signed [32:0] prod_rnd;
  logic signed [32:0] q_sh;
  logic signed [15:0] q16;
  logic signed [16:0] sum17;
  logic signed [15:0] acc_sat;

  assign in_ready  = (state_q == S_IDLE) && system1000_rstn;
  assign accept    = in_valid && in_ready;
  assign coef_ok   = (state_q == S_IDLE) && coef_we
                     && (32'(coef_addr) < TAPS);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;

  // Round-to-nearest product, then saturating accumulate.
  always_comb begin
    prod     = x_q[idx_q] * c_q[idx_q];
    prod_rnd = 33'(prod) + 33'sd16384;
    q_sh     = prod_rnd >>> 15;
    q16      = q_sh[15:0];
    unique case (1'b1)
      (q_sh > 33'sd32767):  q16 = 16'sh7fff;
      (q_sh < -33'sd32768): q16 = 16'sh8000;
      default:              q16 = q_sh[15:0];
    endcase
    sum17   = {acc_q[15], acc_q} + {q16[15], q16};
    acc_sat = sum17[15:0];
    if (sum17[16] != sum17[15]) begin
      acc_sat = sum17[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    c_d        = c_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    if (coef_ok) begin
      c_d[coef_addr] = coef_data;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sat;
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(TAPS - 1)) begin
          idx_d      = '0;
          out_data_d = acc_sat;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      x_q        <= x_d;
      c_q        <= c_d;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: directed samples with
// hand-computed Q1.15 results, checked by a separate output monitor.
module tb_fir_serial_mac;

  localparam int TAPS = 4;
  localparam int AW   = 2;
  localparam int LAT  = TAPS + 1;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_data;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_ready;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q [$];

  fir_serial_mac #(.TAPS(TAPS)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .coef_we         (coef_we),
    .coef_addr       (coef_addr),
    .coef_data       (coef_data),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: pops one expectation per output handshake.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rstn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none",
                   out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {16'h0, out_data}, {16'h0, e});
        end
      end
    end
  end

  task automatic write_coef(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic set_coefs(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
    write_coef(2'd0, c0);
    write_coef(2'd1, c1);
    write_coef(2'd2, c2);
    write_coef(2'd3, c3);
  endtask

  // Returns at the falling edge right after the accept edge.
  task automatic push(input logic [15:0] d, input logic [15:0] e,
                      input bit has_exp, input bit we,
                      input logic [AW-1:0] a, input logic [15:0] cd);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    coef_we  = we;
    coef_addr = a;
    coef_data = cd;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (has_exp) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    #1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic sample(input logic [15:0] d, input logic [15:0] e);
    int lat;
    push(d, e, 1'b1, 1'b0, '0, '0);
    wait_valid(lat);
    check("latency", lat, LAT);
  endtask

  logic [15:0] imp_in  [5] = '{16'h7fff, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] imp_out [5] = '{16'h4000, 16'h2000, 16'h1000,
                               16'h0800, 16'h0000};
  logic [15:0] pos_out [4] = '{16'h7ffe, 16'h7fff, 16'h7fff, 16'h7fff};

  initial begin
    int lat;
    bit seen;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data", {16'h0, out_data}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_in_ready", {31'h0, in_ready}, 32'd1);

    // Impulse response
    set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    for (int i = 0; i < 5; i++) sample(imp_in[i], imp_out[i]);

    // Positive accumulate saturation
    set_coefs(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    for (int i = 0; i < 4; i++) sample(16'h7fff, pos_out[i]);

    // 0x8000 * 0x8000 product corner, then flush the delay line
    set_coefs(16'h8000, 16'h0000, 16'h0000, 16'h0000);
    sample(16'h8000, 16'h7fff);
    for (int i = 0; i < 4; i++) sample(16'h0000, 16'h0000);

    // Negative saturation
    set_coefs(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    sample(16'h8000, 16'h8001);
    sample(16'h8000, 16'h8000);

    // Backpressure: output held, stray in_valid ignored
    set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    @(negedge clk);
    out_ready = 1'b0;
    sample(16'h0100, 16'hd080);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_data  = 16'h1234;
      #1;
      check("bp_out_valid", {31'h0, out_valid}, 32'd1);
      check("bp_out_data", {16'h0, out_data}, 32'h0000d080);
      check("bp_in_ready", {31'h0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_ready", {31'h0, in_ready}, 32'd1);
    sample(16'h0000, 16'he840);

    // Reset in the middle of MAC aborts the sample
    push(16'h7fff, 16'h0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("mac_rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("mac_rst_out_data", {16'h0, out_data}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("mac_rst_no_output", {31'h0, seen}, 32'd0);

    // Coefficients cleared; a write during MAC must not land
    push(16'h7fff, 16'h0000, 1'b1, 1'b0, '0, '0);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 16'h7fff;
    wait_valid(lat);
    coef_we   = 1'b0;
    check("latency", lat, LAT);
    sample(16'h7fff, 16'h0000);

    // Write in the same cycle as accept is used by that sample
    push(16'h7fff, 16'h4000, 1'b1, 1'b1, 2'd0, 16'h4000);
    wait_valid(lat);
    check("latency", lat, LAT);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

Time-multiplexed FIR tap engine for the signed 16-bit Q1.15 sample path. Accepts one sample per handshake, shifts it into a TAPS-deep delay line and then runs TAPS multiply-accumulate cycles through a single 16x16 multiplier. Accumulation is saturating, with the same overflow semantics as the path's saturating adder. It produces one filtered Q1.15 sample per input sample, held until the downstream stage takes it.

## Interface
- TAPS, 4: number of filter taps (2..16); the coefficient address width is AW = clog2(TAPS).
- system1000  in  1  clock; all state changes on the rising edge.
- system1000_rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_data  in  16  signed Q1.15 input sample.
- in_ready  out  1  block can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index; index 0 multiplies the newest sample.
- coef_data  in  16  signed Q1.15 coefficient.
- out_valid  out  1  out_data is valid.
- out_data  out  16  signed Q1.15 filtered sample.
- out_ready  in  1  downstream accepts out_data.

## Operation
- State machine:
  - IDLE: in_ready=1. On in_valid: shift the delay line (x[0]<=in_data, x[k]<=x[k-1]), clear acc, set idx=0, go to MAC.
  - MAC: one tap per cycle, idx 0..TAPS-1. After idx=TAPS-1, go to OUT.
  - OUT: out_valid=1, out_data=acc. On out_ready, go to IDLE.
- Per-tap arithmetic, in order:
  - p32 = x[idx]*c[idx], full signed 32-bit product.
  - Round: q = (p32 + 0x4000) >>> 15, arithmetic shift, evaluated at 33-bit width.
  - Saturate q to 16 bits. This only triggers for 0x8000*0x8000, which gives 0x7FFF.
  - acc <= sat16(acc + q). On signed overflow, clamp to 0x7FFF if both operands are non-negative, else to 0x8000.
  - Saturation is applied at every step, so the tap order (0 first) is normative.
- Coefficient writes:
  - Taken only in IDLE, and only when coef_addr < TAPS. Otherwise ignored.
  - A write and a sample accept in the same IDLE cycle are both performed. The new coefficient is used for that sample.
- Reset (system1000_rstn=0 at an edge):
  - State goes to IDLE. Delay line, coefficients and acc are cleared to 0.
  - out_valid=0, out_data=0.
  - in_ready=0 while reset is asserted.
  - A reset mid-MAC or mid-OUT aborts the sample; it is never output.
- Output stability: out_data and out_valid hold constant while out_valid=1 and out_ready=0.

## Timing
- Accept edge T (in_valid & in_ready): MAC occupies cycles T+1..T+TAPS, and out_valid rises after edge T+TAPS.
  - Latency from the accept edge to out_valid is TAPS+1 cycles.
- Output handshake edge U (out_valid & out_ready): IDLE and in_ready=1 from U onward. No accept can occur in the same cycle as the output handshake.
- Maximum throughput is one sample per TAPS+2 cycles.
- in_ready=0 throughout MAC and OUT. in_valid is ignored there, and its data is neither latched nor dropped silently into state.
- First cycle after reset release: IDLE, in_ready=1.
- out_data is registered. It updates only when entering OUT, and is cleared only by reset.

## Test plan
- Impulse:
  - Stimulus: TAPS=4, coefs {0x4000,0x2000,0x1000,0x0800}; input 0x7FFF, then four 0x0000.
  - Response: outputs 0x4000, 0x2000, 0x1000, 0x0800, 0x0000.
  - Each out_valid rises exactly 5 cycles after its accept.
- Positive accumulate saturation:
  - Stimulus: all coefs 0x7FFF; inputs 0x7FFF x4.
  - Response: 0x7FFE, then 0x7FFF, 0x7FFF, 0x7FFF.
- Product corner:
  - Stimulus: coef0=0x8000, others 0; input 0x8000.
  - Response: 0x7FFF. Then input 0x0000 gives 0x0000.
- Negative saturation:
  - Stimulus: all coefs 0x7FFF; inputs 0x8000 x2.
  - Response: 0x8001, then 0x8000 (clamped).
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in OUT while pulsing in_valid with 0x1234.
  - Response: out_valid/out_data stable and in_ready=0. The next output reflects no 0x1234 sample. Releasing out_ready returns in_ready=1 on the following cycle.
- Reset mid-MAC:
  - Stimulus: assert rstn=0 for 1 cycle at MAC idx=2.
  - Response: out_valid never rises for that sample. in_ready=1 after release. Coefs read back 0, so the next input 0x7FFF outputs 0x0000.
  - Also check: a coef write with coef_addr>=TAPS, or issued during MAC, has no effect.
